// File: rtl/serial_magnitude_comparator.sv
// Purpose: multi-cycle unsigned N-bit magnitude comparator, scans operands MSB-first one bit per clock.
// Latency: exactly N cycles from operand accept to out_valid; no early exit.
// Backpressure: in_ready only in IDLE; result and flags held in DONE until out_ready.
module serial_magnitude_comparator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         A_lt_B,
  output logic         A_eq_B,
  output logic         A_gt_B
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          decided_q, decided_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          lt_q, lt_d;
  logic          eq_q, eq_d;
  logic          gt_q, gt_d;

  // Current bit pair under comparison is always the top of the shift registers.
  logic a_bit, b_bit;
  assign a_bit = a_sh_q[N-1];
  assign b_bit = b_sh_q[N-1];

  // Next-state and next-output logic for the IDLE -> CMP -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    cnt_d       = cnt_q;
    decided_d   = decided_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d     = A;
          b_sh_d     = B;
          cnt_d      = '0;
          decided_d  = 1'b0;
          lt_d       = 1'b0;
          eq_d       = 1'b0;
          gt_d       = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ST_CMP;
        end
      end
      ST_CMP: begin
        // First differing bit from the MSB settles the answer; later bits are don't-care.
        if (!decided_q && (a_bit != b_bit)) begin
          lt_d      = ~a_bit & b_bit;
          gt_d      = a_bit & ~b_bit;
          decided_d = 1'b1;
        end
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q << 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Equality is only known once the final bit has also matched.
          if (!decided_q && (a_bit == b_bit)) begin
            eq_d = 1'b1;
          end
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          lt_d        = 1'b0;
          eq_d        = 1'b0;
          gt_d        = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        lt_d        = 1'b0;
        eq_d        = 1'b0;
        gt_d        = 1'b0;
      end
    endcase
  end

  // All state and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      cnt_q       <= cnt_d;
      decided_q   <= decided_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign A_lt_B    = lt_q;
  assign A_eq_B    = eq_q;
  assign A_gt_B    = gt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: N=8 vector table plus hand sequences,
// and an N=1 instance for the single-cycle corner.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [7:0] A, B;
  logic       in_ready, out_valid, lt, eq, gt;

  logic       in1_valid, out1_ready;
  logic [0:0] A1, B1;
  logic       in1_ready, out1_valid, lt1, eq1, gt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .A_lt_B(lt), .A_eq_B(eq), .A_gt_B(gt)
  );

  serial_magnitude_comparator #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready),
    .A(A1), .B(B1), .out_valid(out1_valid), .out_ready(out1_ready),
    .A_lt_B(lt1), .A_eq_B(eq1), .A_gt_B(gt1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       lt;
    logic       eq;
    logic       gt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Accept one operand pair on the N=8 instance and return edges until out_valid.
  task automatic do_cmp(input logic [7:0] a, input logic [7:0] b, input bit wiggle,
                        output int lat);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_low_in_cmp", int'(in_ready), 0);
    in_valid = wiggle;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (wiggle) begin
        A = 8'($urandom);
        B = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  // Hand the result back and confirm the block is ready again the next cycle.
  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_cleared"}, int'(out_valid), 0);
    check({tag, "_flags_cleared"}, int'({lt, eq, gt}), 0);
    check({tag, "_in_ready_back"}, int'(in_ready), 1);
  endtask

  task automatic do_cmp1(input logic a, input logic b, input int exp_flags);
    int lat;
    @(negedge clk);
    A1 = a; B1 = b; in1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in1_valid = 1'b0;
    lat = 0;
    while (!out1_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("n1_latency", lat, 1);
    check("n1_flags", int'({lt1, eq1, gt1}), exp_flags);
    out1_ready = 1'b1;
    @(negedge clk);
    out1_ready = 1'b0;
    check("n1_in_ready_back", int'(in1_ready), 1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'hFE, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    in1_valid = 1'b0; out1_ready = 1'b0; A1 = '0; B1 = '0;
    #12;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_flags", int'({lt, eq, gt}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors: fixed latency and one-hot result for each pair.
    for (int i = 0; i < 8; i++) begin
      do_cmp(vecs[i].a, vecs[i].b, 1'b0, lat);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_flags", i), int'({lt, eq, gt}),
            int'({vecs[i].lt, vecs[i].eq, vecs[i].gt}));
      release_result($sformatf("vec%0d", i));
    end

    // LSB-decided pair with A/B and in_valid toggling during CMP, then hold in DONE.
    do_cmp(8'h12, 8'h13, 1'b1, lat);
    check("wiggle_latency", lat, 8);
    check("wiggle_flags", int'({lt, eq, gt}), 3'b100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_out_valid", k), int'(out_valid), 1);
      check($sformatf("hold%0d_flags", k), int'({lt, eq, gt}), 3'b100);
      check($sformatf("hold%0d_in_ready", k), int'(in_ready), 0);
    end
    release_result("hold");

    // Reset during the third CMP cycle, after the MSB has already decided gt.
    @(negedge clk);
    A = 8'h80; B = 8'h00; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_flags", int'({lt, eq, gt}), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    begin
      int stray = 0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (out_valid) stray++;
      end
      check("midrst_no_stray_valid", stray, 0);
    end
    check("midrst_idle_ready", int'(in_ready), 1);

    // Single-bit instance corner cases.
    do_cmp1(1'b1, 1'b0, 3'b001);
    do_cmp1(1'b0, 1'b0, 3'b010);
    do_cmp1(1'b0, 1'b1, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
